fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_pkg.sv | 40 ++++
 rtl/fetch_unit_jump_lut.sv | 17 +
 rtl/fetch_unit.sv | 155 +++++++++++++++
 tb/tb_fetch_unit.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the fetch unit: default widths, opcode encodings,
// sequencer state type and the conditional-jump predicate.
package fetch_unit_pkg;

  localparam int unsigned PC_W_DEF   = 10;
  localparam int unsigned IW_DEF     = 9;
  localparam int unsigned LUT_AW_DEF = 5;

  localparam logic [3:0] OP_JMP  = 4'b0000;
  localparam logic [3:0] OP_JEQ  = 4'b0001;
  localparam logic [3:0] OP_JNE  = 4'b0010;
  localparam logic [3:0] OP_JLT  = 4'b0011;
  localparam logic [3:0] OP_JGE  = 4'b0100;
  localparam logic [3:0] OP_HALT = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_RUN,
    ST_DONE
  } fetch_state_e;

  // Flag condition for conditional jumps; unconditional jumps are qualified
  // separately by the decoder's UncondJump strobe.
  function automatic logic cond_met(input logic [3:0] opcode,
                                    input logic       flag_z,
                                    input logic       flag_n);
    logic met;
    met = 1'b0;
    case (opcode)
      OP_JEQ:  met = flag_z;
      OP_JNE:  met = !flag_z;
      OP_JLT:  met = flag_n;
      OP_JGE:  met = !flag_n;
      default: met = 1'b0;
    endcase
    return met;
  endfunction

endpackage

// File: rtl/fetch_unit_jump_lut.sv
// Jump-target lookup ROM: 2^LUT_AW entries of PC_W bits, combinational read.
// Contents are fixed at elaboration through the packed LUT_INIT parameter.
module jump_lut #(
  parameter int unsigned                          PC_W     = 10,
  parameter int unsigned                          LUT_AW   = 5,
  parameter logic [(2**LUT_AW)*PC_W-1:0]          LUT_INIT = '0
) (
  input  logic [LUT_AW-1:0] idx,
  output logic [PC_W-1:0]   target
);

  // Entry i occupies LUT_INIT[i*PC_W +: PC_W].
  always_comb begin
    target = LUT_INIT[PC_W*int'(idx) +: PC_W];
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch sequencer: IDLE -> FILL -> RUN -> DONE, with a one-cycle
// squash bubble after taken jumps. Optional taken-jump counter: FETCH_PERF_CNT_EN.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int unsigned                 PC_W     = PC_W_DEF,
  parameter int unsigned                 IW       = IW_DEF,
  parameter int unsigned                 LUT_AW   = LUT_AW_DEF,
  parameter logic [(2**LUT_AW)*PC_W-1:0] LUT_INIT = '0
) (
  input  logic            Clk,
  input  logic            Reset_n,
  input  logic            Start,
  input  logic [PC_W-1:0] StartAddr,
  input  logic [IW-1:0]   InstrIn,
  input  logic            UncondJump,
  input  logic            JType,
  input  logic            FlagZ,
  input  logic            FlagN,
  output logic [PC_W-1:0] PC,
  output logic [IW-1:0]   Instr,
  output logic [3:0]      Opcode,
  output logic            Valid,
  output logic            Done
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [15:0]     TakenCnt
`endif
);

  fetch_state_e    state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [IW-1:0]   instr_q, instr_d;
  logic            squash_q, squash_d;
  logic            done_q, done_d;

  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] lut_target;
  logic [3:0]      opcode;
  logic            valid;
  logic            halt;
  logic            taken;
  logic            start_accept;

  jump_lut #(
    .PC_W     (PC_W),
    .LUT_AW   (LUT_AW),
    .LUT_INIT (LUT_INIT)
  ) u_jump_lut (
    .idx    (instr_q[LUT_AW-1:0]),
    .target (lut_target)
  );

  assign opcode       = instr_q[IW-1:IW-4];
  assign pc_inc       = pc_q + 1'b1;
  assign valid        = (state_q == ST_RUN) && !squash_q;
  assign start_accept = Start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

  // Halt outranks jump; both are ignored in a squashed slot.
  assign halt  = valid && (opcode == OP_HALT);
  assign taken = valid && !halt && JType &&
                 (UncondJump || cond_met(opcode, FlagZ, FlagN));

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    squash_d = squash_q;
    done_d   = done_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (Start) begin
          pc_d     = StartAddr;
          done_d   = 1'b0;
          squash_d = 1'b0;
          state_d  = ST_FILL;
        end
      end
      ST_FILL: begin
        instr_d  = InstrIn;
        pc_d     = pc_inc;
        squash_d = 1'b0;
        state_d  = ST_RUN;
      end
      ST_RUN: begin
        if (halt) begin
          done_d  = 1'b1;
          state_d = ST_DONE;
        end else if (taken) begin
          // The fall-through word is still captured, but flagged dead.
          instr_d  = InstrIn;
          pc_d     = lut_target;
          squash_d = 1'b1;
        end else begin
          instr_d  = InstrIn;
          pc_d     = pc_inc;
          squash_d = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q  <= ST_IDLE;
      pc_q     <= '0;
      instr_q  <= '0;
      squash_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      squash_q <= squash_d;
      done_q   <= done_d;
    end
  end

  assign PC     = pc_q;
  assign Instr  = instr_q;
  assign Opcode = opcode;
  assign Valid  = valid;
  assign Done   = done_q;

`ifdef FETCH_PERF_CNT_EN
  logic [15:0] taken_cnt_q, taken_cnt_d;

  always_comb begin
    taken_cnt_d = taken_cnt_q;
    if (start_accept) begin
      taken_cnt_d = '0;
    end else if (taken && (taken_cnt_q != 16'hFFFF)) begin
      taken_cnt_d = taken_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      taken_cnt_q <= '0;
    end else begin
      taken_cnt_q <= taken_cnt_d;
    end
  end

  assign TakenCnt = taken_cnt_q;
`else
  // start_accept only feeds the optional counter.
  logic unused_start_accept;
  assign unused_start_accept = start_accept;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: straight-line fetch, taken/not-taken jumps,
// PC wrap, halt/restart and asynchronous reset during a taken jump.
module tb_fetch_unit;

  localparam int unsigned PC_W   = 10;
  localparam int unsigned IW     = 9;
  localparam int unsigned LUT_AW = 5;

  function automatic logic [(2**LUT_AW)*PC_W-1:0] mk_lut();
    logic [(2**LUT_AW)*PC_W-1:0] l;
    l = '0;
    l[3*PC_W +: PC_W] = 10'h080;
    l[5*PC_W +: PC_W] = 10'h3FD;
    l[6*PC_W +: PC_W] = 10'h01E;
    return l;
  endfunction

  localparam logic [(2**LUT_AW)*PC_W-1:0] LUT = mk_lut();

  logic            Clk;
  logic            Reset_n;
  logic            Start;
  logic [PC_W-1:0] StartAddr;
  logic [IW-1:0]   InstrIn;
  logic            UncondJump;
  logic            JType;
  logic            FlagZ;
  logic            FlagN;
  logic [PC_W-1:0] PC;
  logic [IW-1:0]   Instr;
  logic [3:0]      Opcode;
  logic            Valid;
  logic            Done;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0]     TakenCnt;
`endif

  logic [IW-1:0] rom [1024];

  int unsigned n_vec;
  int unsigned n_err;

  fetch_unit #(
    .PC_W     (PC_W),
    .IW       (IW),
    .LUT_AW   (LUT_AW),
    .LUT_INIT (LUT)
  ) dut (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .Start      (Start),
    .StartAddr  (StartAddr),
    .InstrIn    (InstrIn),
    .UncondJump (UncondJump),
    .JType      (JType),
    .FlagZ      (FlagZ),
    .FlagN      (FlagN),
    .PC         (PC),
    .Instr      (Instr),
    .Opcode     (Opcode),
    .Valid      (Valid),
    .Done       (Done)
`ifdef FETCH_PERF_CNT_EN
    ,
    .TakenCnt   (TakenCnt)
`endif
  );

  // Instruction ROM and a minimal decoder for the jump opcodes.
  assign InstrIn    = rom[PC];
  assign JType      = (Instr[8:5] <= 4'd4);
  assign UncondJump = (Instr[8:5] == 4'd0);

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic logic [IW-1:0] filler(input logic [9:0] a);
    return {4'b0101, a[4:0]};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #2;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    for (int unsigned a = 0; a < 1024; a++) rom[a] = filler(10'(a));
    rom[10'h013] = {4'b0000, 5'd3};  // JMP  -> 0x080
    rom[10'h082] = {4'b0001, 5'd5};  // JEQ  (Z=0, not taken)
    rom[10'h084] = {4'b0001, 5'd5};  // JEQ  (Z=1, taken -> 0x3FD)
    rom[10'h000] = {4'b0000, 5'd6};  // JMP  -> 0x01E
    rom[10'h020] = {4'b1111, 5'd0};  // HALT

    Reset_n   = 1'b0;
    Start     = 1'b0;
    StartAddr = '0;
    FlagZ     = 1'b0;
    FlagN     = 1'b0;
    step();
    step();
    check("rst_pc", 32'(PC), 32'h0);
    check("rst_instr", 32'(Instr), 32'h0);
    check("rst_valid", 32'(Valid), 32'h0);
    check("rst_done", 32'(Done), 32'h0);
`ifdef FETCH_PERF_CNT_EN
    check("rst_cnt", 32'(TakenCnt), 32'h0);
`endif
    Reset_n = 1'b1;
    step();
    check("idle_valid", 32'(Valid), 32'h0);

    Start = 1'b1;
    StartAddr = 10'h010;
    step();
    Start = 1'b0;
    check("fill_pc", 32'(PC), 32'h010);
    check("fill_valid", 32'(Valid), 32'h0);
    step();
    check("run0_pc", 32'(PC), 32'h011);
    check("run0_valid", 32'(Valid), 32'h1);
    check("run0_instr", 32'(Instr), 32'(filler(10'h010)));
    Start = 1'b1;
    StartAddr = 10'h200;
    step();
    Start = 1'b0;
    check("start_ign_pc", 32'(PC), 32'h012);
    check("start_ign_instr", 32'(Instr), 32'(filler(10'h011)));
    step();
    step();
    check("jmp_instr", 32'(Instr), 32'h003);
    check("jmp_valid", 32'(Valid), 32'h1);
    check("jmp_pc", 32'(PC), 32'h014);
    step();
    check("jmp_tgt_pc", 32'(PC), 32'h080);
    check("jmp_bubble", 32'(Valid), 32'h0);
`ifdef FETCH_PERF_CNT_EN
    check("cnt_after_jmp", 32'(TakenCnt), 32'h1);
`endif
    step();
    check("tgt_valid", 32'(Valid), 32'h1);
    check("tgt_instr", 32'(Instr), 32'(filler(10'h080)));
    check("tgt_pc", 32'(PC), 32'h081);
    step();
    step();
    check("jeq_nt_instr", 32'(Instr), 32'h025);
    step();
    check("jeq_nt_pc", 32'(PC), 32'h084);
    check("jeq_nt_valid", 32'(Valid), 32'h1);
    check("jeq_nt_instr2", 32'(Instr), 32'(filler(10'h083)));
    FlagZ = 1'b1;
    step();
    check("jeq_t_instr", 32'(Instr), 32'h025);
    step();
    FlagZ = 1'b0;
    check("jeq_t_pc", 32'(PC), 32'h3FD);
    check("jeq_t_bubble", 32'(Valid), 32'h0);
`ifdef FETCH_PERF_CNT_EN
    check("cnt_after_jeq", 32'(TakenCnt), 32'h2);
`endif
    step();
    step();
    check("pre_wrap_pc", 32'(PC), 32'h3FF);
    step();
    check("wrap_pc", 32'(PC), 32'h000);
    check("wrap_instr", 32'(Instr), 32'(filler(10'h3FF)));
    step();
    step();
    check("jmp2_pc", 32'(PC), 32'h01E);
    step();
    step();
    step();
    check("halt_instr_op", 32'(Opcode), 32'hF);
    check("halt_instr_valid", 32'(Valid), 32'h1);
    check("halt_pre_done", 32'(Done), 32'h0);
    step();
    check("halt_done", 32'(Done), 32'h1);
    check("halt_valid", 32'(Valid), 32'h0);
    check("halt_pc", 32'(PC), 32'h021);
    for (int i = 0; i < 3; i++) step();
    check("frozen_pc", 32'(PC), 32'h021);
    check("frozen_done", 32'(Done), 32'h1);
    check("frozen_valid", 32'(Valid), 32'h0);

    Start = 1'b1;
    StartAddr = 10'h000;
    step();
    Start = 1'b0;
    check("restart_pc", 32'(PC), 32'h000);
    check("restart_done", 32'(Done), 32'h0);
`ifdef FETCH_PERF_CNT_EN
    check("restart_cnt", 32'(TakenCnt), 32'h0);
`endif
    step();
    check("restart_instr", 32'(Instr), 32'h006);
    check("restart_valid", 32'(Valid), 32'h1);

    Reset_n = 1'b0;
    #1;
    check("async_pc", 32'(PC), 32'h0);
    check("async_instr", 32'(Instr), 32'h0);
    check("async_valid", 32'(Valid), 32'h0);
    check("async_done", 32'(Done), 32'h0);
    check("async_op", 32'(Opcode), 32'h0);
`ifdef FETCH_PERF_CNT_EN
    check("async_cnt", 32'(TakenCnt), 32'h0);
`endif
    step();
    Reset_n = 1'b1;
    step();
    step();
    check("post_rst_pc", 32'(PC), 32'h0);
    check("post_rst_valid", 32'(Valid), 32'h0);
    check("post_rst_instr", 32'(Instr), 32'h0);

    Start = 1'b1;
    StartAddr = 10'h010;
    step();
    Start = 1'b0;
    step();
    check("resume_valid", 32'(Valid), 32'h1);
    check("resume_instr", 32'(Instr), 32'(filler(10'h010)));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
